// File: rtl/pio_out_blink.sv
// Avalon-MM output PIO with set/clear/toggle strobes and a per-bit blink mode.
// A programmable prescaler sets the blink half-period; reads are combinational with zero wait states.
module pio_out_blink #(
    parameter int WIDTH      = 10,
    parameter int PRESCALE_W = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [WIDTH-1:0]  out_port
);

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_BLINK_EN = 3'd1;
    localparam logic [2:0] ADDR_PERIOD   = 3'd2;
    localparam logic [2:0] ADDR_OUT      = 3'd3;
    localparam logic [2:0] ADDR_SET      = 3'd4;
    localparam logic [2:0] ADDR_CLEAR    = 3'd5;
    localparam logic [2:0] ADDR_TOGGLE   = 3'd6;

    localparam logic [PRESCALE_W-1:0] CNT_ZERO = {PRESCALE_W{1'b0}};
    localparam logic [PRESCALE_W-1:0] CNT_ONE  = PRESCALE_W'(32'd1);

    logic                  wr_s;
    logic [WIDTH-1:0]      wdata_s;
    logic [WIDTH-1:0]      data_r;
    logic [WIDTH-1:0]      blink_en_r;
    logic [PRESCALE_W-1:0] period_r;
    logic [PRESCALE_W-1:0] counter_r;
    logic                  phase_r;
    logic                  period_wr_s;
    logic                  unused_s;

    assign wr_s        = chipselect & ~write_n;
    assign wdata_s     = writedata[WIDTH-1:0];
    assign period_wr_s = wr_s & (address == ADDR_PERIOD);
    // Upper writedata bits beyond WIDTH/PRESCALE_W are intentionally dropped.
    assign unused_s    = ^writedata;

    // DATA register: plain write plus set/clear/toggle strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_r <= {WIDTH{1'b0}};
        end else if (wr_s) begin
            case (address)
                ADDR_DATA:   data_r <= wdata_s;
                ADDR_SET:    data_r <= data_r | wdata_s;
                ADDR_CLEAR:  data_r <= data_r & ~wdata_s;
                ADDR_TOGGLE: data_r <= data_r ^ wdata_s;
                default:     data_r <= data_r;
            endcase
        end
    end

    // BLINK_EN mask and PERIOD configuration registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_en_r <= {WIDTH{1'b0}};
            period_r   <= CNT_ZERO;
        end else begin
            if (wr_s && (address == ADDR_BLINK_EN)) begin
                blink_en_r <= wdata_s;
            end
            if (period_wr_s) begin
                period_r <= writedata[PRESCALE_W-1:0];
            end
        end
    end

    // Blink prescaler; a PERIOD write restarts the half-period and beats a same-cycle reload.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter_r <= CNT_ZERO;
            phase_r   <= 1'b1;
        end else if (period_wr_s) begin
            counter_r <= writedata[PRESCALE_W-1:0];
            phase_r   <= 1'b1;
        end else if (period_r == CNT_ZERO) begin
            counter_r <= CNT_ZERO;
            phase_r   <= 1'b1;
        end else if (counter_r == CNT_ZERO) begin
            counter_r <= period_r;
            phase_r   <= ~phase_r;
        end else begin
            counter_r <= counter_r - CNT_ONE;
        end
    end

    assign out_port = (data_r & ~blink_en_r) | (data_r & blink_en_r & {WIDTH{phase_r}});

    // Zero-latency read mux; write-only and reserved addresses read as zero.
    always_comb begin
        readdata = 32'd0;
        case (address)
            ADDR_DATA:     readdata[WIDTH-1:0]      = data_r;
            ADDR_BLINK_EN: readdata[WIDTH-1:0]      = blink_en_r;
            ADDR_PERIOD:   readdata[PRESCALE_W-1:0] = period_r;
            ADDR_OUT:      readdata[WIDTH-1:0]      = out_port;
            default:       readdata                 = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_pio_out_blink.sv
// Self-checking bench for pio_out_blink: table-driven register vectors plus blink timing sequences,
// with expected values queued on a scoreboard when stimulus is driven.
module tb_pio_out_blink;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [9:0]  out_port;
    logic [31:0] readdata4;
    logic [3:0]  out_port4;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [2:0]  raddr;
        logic [31:0] exp_rd;
        logic [9:0]  exp_out;
    } vec_t;
    vec_t vecs[9];

    pio_out_blink dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
    );

    pio_out_blink #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata4), .out_port(out_port4)
    );

    always #5 clk = ~clk;

    task automatic sb_push(input string n, input logic [31:0] e);
        sb_q.push_back('{n, e});
    endtask

    task automatic sb_check(input logic [31:0] act);
        sb_t s;
        total_cnt++;
        if (sb_q.size() == 0) begin
            $display("FAIL scoreboard_empty: got %h, nothing expected", act);
        end else begin
            s = sb_q.pop_front();
            if (act === s.exp) pass_cnt++;
            else $display("FAIL %s: got %h expected %h", s.name, act, s.exp);
        end
    endtask

    // Drives one write cycle; returns 1 time unit after the capturing edge.
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic check_read(input string n, input logic [2:0] a, input logic [31:0] e);
        sb_push(n, e);
        address = a;
        #1;
        sb_check(readdata);
    endtask

    task automatic check_out(input string n, input logic [9:0] e);
        sb_push(n, {22'd0, e});
        sb_check({22'd0, out_port});
    endtask

    initial begin
        vecs[0] = '{3'd0, 32'h0000_00F0, 3'd3, 32'h0000_00F0, 10'h0F0};
        vecs[1] = '{3'd4, 32'h0000_0003, 3'd3, 32'h0000_00F3, 10'h0F3};
        vecs[2] = '{3'd5, 32'h0000_0030, 3'd3, 32'h0000_00C3, 10'h0C3};
        vecs[3] = '{3'd6, 32'h0000_0101, 3'd3, 32'h0000_01C2, 10'h1C2};
        vecs[4] = '{3'd0, 32'hFFFF_FFFF, 3'd0, 32'h0000_03FF, 10'h3FF};
        vecs[5] = '{3'd1, 32'h0000_0000, 3'd1, 32'h0000_0000, 10'h3FF};
        vecs[6] = '{3'd7, 32'h0000_0123, 3'd7, 32'h0000_0000, 10'h3FF};
        vecs[7] = '{3'd4, 32'h0000_0ABC, 3'd4, 32'h0000_0000, 10'h3FF};
        vecs[8] = '{3'd2, 32'h0000_0000, 3'd2, 32'h0000_0000, 10'h3FF};

        reset      = 1'b1;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check_out("reset_out", 10'h000);
        check_read("reset_rd_data", 3'd0, 32'd0);
        reset = 1'b0;

        // Start a blink, then reset asynchronously mid-count.
        bus_write(3'd0, 32'h3FF);
        bus_write(3'd1, 32'h3FF);
        bus_write(3'd2, 32'd1);
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_out("midblink_reset_out", 10'h000);
        check_read("midblink_reset_period", 3'd2, 32'd0);
        check_read("midblink_reset_blink_en", 3'd1, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        bus_write(3'd0, 32'h3FF);
        check_out("post_reset_data_out", 10'h3FF);
        check_read("post_reset_data_rd", 3'd0, 32'h0000_03FF);

        // Register map vectors.
        for (int i = 0; i < 9; i++) begin
            bus_write(vecs[i].addr, vecs[i].wdata);
            check_out($sformatf("vec%0d_out", i), vecs[i].exp_out);
            check_read($sformatf("vec%0d_rd", i), vecs[i].raddr, vecs[i].exp_rd);
        end

        // Blink bit 0 with PERIOD=3: half-period of 4 cycles, starting high.
        bus_write(3'd0, 32'h3FF);
        bus_write(3'd1, 32'h001);
        bus_write(3'd2, 32'd3);
        for (int k = 0; k < 12; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            check_out($sformatf("blink_k%0d", k), ((k / 4) % 2 == 0) ? 10'h3FF : 10'h3FE);
        end
        check_read("blink_period_rd", 3'd2, 32'd3);

        // PERIOD rewrite on the terminal-count cycle suppresses that toggle.
        bus_write(3'd2, 32'd3);
        repeat (3) @(posedge clk);
        #1;
        bus_write(3'd2, 32'd5);
        for (int k = 0; k < 7; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            check_out($sformatf("rewrite_k%0d", k), (k < 6) ? 10'h3FF : 10'h3FE);
        end

        // PERIOD=0 disables blinking; reserved address write is ignored.
        bus_write(3'd1, 32'h3FF);
        bus_write(3'd0, 32'h155);
        bus_write(3'd2, 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check_out($sformatf("steady_k%0d", k), 10'h155);
        end
        bus_write(3'd7, 32'hFFFF_FFFF);
        check_out("reserved_wr_out", 10'h155);
        check_read("reserved_rd", 3'd7, 32'd0);
        check_read("reserved_data_rd", 3'd0, 32'h0000_0155);
        check_read("reserved_blink_en_rd", 3'd1, 32'h0000_03FF);
        check_read("reserved_out_rd", 3'd3, 32'h0000_0155);

        // Narrow instance: upper writedata bits are dropped.
        bus_write(3'd0, 32'hFFFF_FFFF);
        address = 3'd0;
        #1;
        sb_push("w4_data_rd", 32'h0000_000F);
        sb_check(readdata4);
        sb_push("w4_out", 32'h0000_000F);
        sb_check({28'd0, out_port4});

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
